// File: rtl/qu_pipeline_ctrl.sv
// qu_pipeline_ctrl: front-end stall / warm-up / drain-then-flush sequencer for the Qu core.
// Optional upstream stall propagation is enabled by defining QU_PIPE_CTRL_STALL_CHAIN_EN.
module qu_pipeline_ctrl #(
  parameter int WARMUP_CYCLES = 20,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_req,
  input  logic       fifo_if_id_full,
  input  logic       fifo_id_mp_full,
  input  logic       fifo_mp_rn_full,
  input  logic       fifo_if_id_empty,
  input  logic       fifo_id_mp_empty,
  input  logic       fifo_mp_rn_empty,
  input  logic       rn_ready,
  input  logic       flush_req,
  output logic       if_stall,
  output logic       id_stall,
  output logic       mp_stall,
  output logic       rn_stall,
  output logic       schedule_en,
  output logic       fifo_flush,
  output logic [1:0] ctrl_state,
  output logic       drain_timeout
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [7:0] WARM_LAST  = 8'(WARMUP_CYCLES);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       all_empty;
  logic       timeout_hit;
  logic       rn_nx;
  logic       mp_nx;
  logic       id_nx;
  logic       if_nx;

  assign all_empty  = fifo_if_id_empty & fifo_id_mp_empty & fifo_mp_rn_empty;
  assign ctrl_state = state;

  // Empty FIFOs win over the timeout when both happen on the same edge.
  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      WARMUP: begin
        if (flush_req)              state_nx = DRAIN;
        else if (cnt == WARM_LAST)  state_nx = RUN;
      end
      RUN: begin
        if (flush_req)              state_nx = DRAIN;
      end
      DRAIN: begin
        if (all_empty) begin
          state_nx = FLUSH;
        end else if (cnt == DRAIN_LAST) begin
          state_nx    = FLUSH;
          timeout_hit = 1'b1;
        end
      end
      default: state_nx = WARMUP;
    endcase
  end

  always_comb begin
    cnt_nx = cnt;
    if (state_nx != state)                          cnt_nx = 8'd0;
    else if (state == DRAIN)                        cnt_nx = cnt + 8'd1;
    else if ((state == WARMUP) && !stall_req)       cnt_nx = cnt + 8'd1;
  end

  always_comb begin
    rn_nx = stall_req | ~rn_ready;
    mp_nx = stall_req | fifo_mp_rn_full;
    id_nx = stall_req | fifo_id_mp_full;
    if_nx = stall_req | fifo_if_id_full | (state_nx == DRAIN);
`ifdef QU_PIPE_CTRL_STALL_CHAIN_EN
    mp_nx = mp_nx | rn_nx;
    id_nx = id_nx | mp_nx;
    if_nx = if_nx | id_nx;
`else
    mp_nx = mp_nx;
`endif
    if (state_nx == FLUSH) begin
      rn_nx = 1'b1;
      mp_nx = 1'b1;
      id_nx = 1'b1;
      if_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= WARMUP;
      cnt           <= 8'd0;
      if_stall      <= 1'b1;
      id_stall      <= 1'b1;
      mp_stall      <= 1'b1;
      rn_stall      <= 1'b1;
      schedule_en   <= 1'b0;
      fifo_flush    <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      if_stall    <= if_nx;
      id_stall    <= id_nx;
      mp_stall    <= mp_nx;
      rn_stall    <= rn_nx;
      schedule_en <= (state_nx == RUN) & ~stall_req;
      fifo_flush  <= (state_nx == FLUSH);
      if (timeout_hit) drain_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qu_pipeline_ctrl.sv
// tb_qu_pipeline_ctrl: scoreboard bench for qu_pipeline_ctrl with WARMUP_CYCLES=20, DRAIN_TIMEOUT=8.
// Each cycle a reference model pushes the expected outputs; the scenario tasks pop and compare.
module tb_qu_pipeline_ctrl;
  localparam int WARM = 20;
  localparam int DT   = 8;
  // {if, id, mp, rn, schedule_en, fifo_flush, ctrl_state[1:0], drain_timeout}
  localparam logic [8:0] RESET_VEC = 9'b1111_00_00_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_req = 1'b0;
  logic fifo_if_id_full = 1'b0;
  logic fifo_id_mp_full = 1'b0;
  logic fifo_mp_rn_full = 1'b0;
  logic fifo_if_id_empty = 1'b0;
  logic fifo_id_mp_empty = 1'b0;
  logic fifo_mp_rn_empty = 1'b0;
  logic rn_ready = 1'b1;
  logic flush_req = 1'b0;
  logic if_stall, id_stall, mp_stall, rn_stall, schedule_en, fifo_flush, drain_timeout;
  logic [1:0] ctrl_state;
  logic [8:0] obs;

  logic [8:0] sb[$];
  int total = 0;
  int bad = 0;
  logic [1:0] m_state;
  logic [7:0] m_cnt;
  logic       m_dto;

  qu_pipeline_ctrl #(.WARMUP_CYCLES(WARM), .DRAIN_TIMEOUT(DT)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .fifo_if_id_full(fifo_if_id_full), .fifo_id_mp_full(fifo_id_mp_full),
    .fifo_mp_rn_full(fifo_mp_rn_full), .fifo_if_id_empty(fifo_if_id_empty),
    .fifo_id_mp_empty(fifo_id_mp_empty), .fifo_mp_rn_empty(fifo_mp_rn_empty),
    .rn_ready(rn_ready), .flush_req(flush_req),
    .if_stall(if_stall), .id_stall(id_stall), .mp_stall(mp_stall), .rn_stall(rn_stall),
    .schedule_en(schedule_en), .fifo_flush(fifo_flush), .ctrl_state(ctrl_state),
    .drain_timeout(drain_timeout)
  );

  assign obs = {if_stall, id_stall, mp_stall, rn_stall, schedule_en, fifo_flush, ctrl_state, drain_timeout};

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 2'd0;
    m_cnt   = 8'd0;
    m_dto   = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge(output logic [8:0] e);
    logic [1:0] nx;
    logic r, m, i, f, sch, fl;
    nx = m_state;
    case (m_state)
      2'd0: nx = flush_req ? 2'd2 : ((m_cnt == 8'(WARM)) ? 2'd1 : 2'd0);
      2'd1: nx = flush_req ? 2'd2 : 2'd1;
      2'd2: begin
        if (fifo_if_id_empty && fifo_id_mp_empty && fifo_mp_rn_empty) nx = 2'd3;
        else if (m_cnt == 8'(DT - 1)) begin
          nx    = 2'd3;
          m_dto = 1'b1;
        end
      end
      default: nx = 2'd0;
    endcase
    if (nx != m_state) m_cnt = 8'd0;
    else if (m_state == 2'd2 || (m_state == 2'd0 && !stall_req)) m_cnt = m_cnt + 8'd1;
    if (nx == 2'd3) begin
      {f, i, m, r} = 4'hF;
    end else begin
      r = stall_req | ~rn_ready;
      m = stall_req | fifo_mp_rn_full;
      i = stall_req | fifo_id_mp_full;
      f = stall_req | fifo_if_id_full | (nx == 2'd2);
`ifdef QU_PIPE_CTRL_STALL_CHAIN_EN
      m = m | r;
      i = i | m;
      f = f | i;
`endif
    end
    sch = (nx == 2'd1) & ~stall_req;
    fl  = (nx == 2'd3);
    m_state = nx;
    e = {f, i, m, r, sch, fl, nx, m_dto};
  endtask

  task automatic cycle();
    logic [8:0] e;
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    int first_sched = -1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("[TB] FAIL reset_value got=%b want=%b", obs, RESET_VEC); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("[TB] FAIL reset_hold got=%b want=%b", obs, RESET_VEC); end
    rst = 1'b1;
    for (int k = 1; k <= WARM + 1; k++) begin
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL warmup edge=%0d got=%b want=%b", k, obs, e); end
      if (schedule_en === 1'b1 && first_sched < 0) first_sched = k;
    end
    total++;
    if (first_sched != WARM + 1) begin bad++; $display("[TB] FAIL first_schedule_edge got=%0d want=%0d", first_sched, WARM + 1); end
    total++;
    if (ctrl_state !== 2'd1) begin bad++; $display("[TB] FAIL run_state got=%0d want=1", ctrl_state); end
  endtask

  task automatic test_backpressure();
    logic [8:0] e;
    int id_hi = 0;
    for (int k = 0; k < 8; k++) begin
      fifo_id_mp_full = (k >= 1 && k <= 3);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL id_backpressure k=%0d got=%b want=%b", k, obs, e); end
      if (id_stall === 1'b1) id_hi++;
    end
    total++;
    if (id_hi != 3) begin bad++; $display("[TB] FAIL id_stall_cycles got=%0d want=3", id_hi); end
    for (int k = 0; k < 5; k++) begin
      rn_ready = !(k == 1 || k == 2);
      fifo_mp_rn_full = (k == 3);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL rn_mp_backpressure k=%0d got=%b want=%b", k, obs, e); end
    end
  endtask

  task automatic test_clean_flush();
    logic [8:0] e;
    int pulses = 0;
    for (int k = 0; k <= 26; k++) begin
      flush_req = (k == 0);
      fifo_if_id_empty = (k == 4 || k == 5);
      fifo_id_mp_empty = (k == 4 || k == 5);
      fifo_mp_rn_empty = (k == 4 || k == 5);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL clean_flush k=%0d got=%b want=%b", k, obs, e); end
      if (fifo_flush === 1'b1) pulses++;
      if (k <= 3) begin
        total++;
        if (if_stall !== 1'b1 || schedule_en !== 1'b0 || ctrl_state !== 2'd2) begin
          bad++; $display("[TB] FAIL drain_outputs k=%0d if=%b sch=%b st=%0d want 1/0/2", k, if_stall, schedule_en, ctrl_state);
        end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("[TB] FAIL flush_pulses got=%0d want=1", pulses); end
    total++;
    if (drain_timeout !== 1'b0 || ctrl_state !== 2'd1 || schedule_en !== 1'b1) begin
      bad++; $display("[TB] FAIL after_clean_flush dto=%b st=%0d sch=%b want 0/1/1", drain_timeout, ctrl_state, schedule_en);
    end
  endtask

  task automatic test_drain_timeout();
    logic [8:0] e;
    int flush_at = -1;
    for (int k = 0; k <= 30; k++) begin
      flush_req = (k == 0);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL drain_timeout k=%0d got=%b want=%b", k, obs, e); end
      if (fifo_flush === 1'b1 && flush_at < 0) flush_at = k;
    end
    total++;
    if (flush_at != DT) begin bad++; $display("[TB] FAIL timeout_flush_edge got=%0d want=%0d", flush_at, DT); end
    total++;
    if (drain_timeout !== 1'b1 || ctrl_state !== 2'd1) begin
      bad++; $display("[TB] FAIL sticky_timeout dto=%b st=%0d want 1/1", drain_timeout, ctrl_state);
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] e;
    int first_sched = -1;
    for (int k = 0; k <= 56; k++) begin
      flush_req = (k == 0 || k == 23 || k == 25);
      fifo_if_id_empty = (k == 1 || k == 27);
      fifo_id_mp_empty = (k == 1 || k == 27);
      fifo_mp_rn_empty = (k == 1 || k == 27);
      stall_req = (k >= 29 && k <= 33);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL simultaneous k=%0d got=%b want=%b", k, obs, e); end
      if (k == 23 || k == 26) begin
        total++;
        if (ctrl_state !== 2'd2) begin bad++; $display("[TB] FAIL flush_priority k=%0d got=%0d want=2", k, ctrl_state); end
      end
      if (k > 28 && schedule_en === 1'b1 && first_sched < 0) first_sched = k - 28;
    end
    total++;
    if (first_sched != WARM + 1 + 5) begin bad++; $display("[TB] FAIL stalled_warmup_len got=%0d want=%0d", first_sched, WARM + 6); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    for (int k = 0; k < 3; k++) begin
      flush_req = (k == 0);
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL pre_reset_drain k=%0d got=%b want=%b", k, obs, e); end
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== RESET_VEC) begin bad++; $display("[TB] FAIL async_reset got=%b want=%b", obs, RESET_VEC); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      e = sb.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("[TB] FAIL post_reset k=%0d got=%b want=%b", k, obs, e); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_backpressure();
    test_clean_flush();
    test_drain_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qu_pipeline_ctrl.md
# qu_pipeline_ctrl

Front-end pipeline sequencer for the Qu core. It generates the per-stage stall signals (`if_stall`, `id_stall`, `mp_stall`, `rn_stall`) and the scheduler enable `schedule_en` that `qu_core` consumes. Inputs are inter-stage FIFO status, rename readiness, an external stall request and a flush request. It sits beside `qu_core`'s fetch/decode/map/rename chain and owns three things: the post-reset warm-up window, backpressure, and the drain-then-flush sequence.

## Interface
Parameters:
- `WARMUP_CYCLES`, 20: cycles the front end runs after reset or flush before `schedule_en` may assert; range 0..255.
- `DRAIN_TIMEOUT`, 64: maximum cycles spent in DRAIN before forcing FLUSH; range 1..255.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_req`  in  1  global external stall.
- `fifo_if_id_full`, `fifo_id_mp_full`, `fifo_mp_rn_full`  in  1 each  downstream FIFO full flags.
- `fifo_if_id_empty`, `fifo_id_mp_empty`, `fifo_mp_rn_empty`  in  1 each  FIFO empty flags.
- `rn_ready`  in  1  rename resources available.
- `flush_req`  in  1  single-cycle flush request.
- `if_stall`, `id_stall`, `mp_stall`, `rn_stall`  out  1 each  stage stalls.
- `schedule_en`  out  1  scheduler enable.
- `fifo_flush`  out  1  one-cycle FIFO clear pulse.
- `ctrl_state`  out  2  current state encoding.
- `drain_timeout`  out  1  sticky flag: a drain timed out.

## Operation
- States: WARMUP=0, RUN=1, DRAIN=2, FLUSH=3.
- One 8-bit counter `cnt` serves both WARMUP and DRAIN. It clears on every state entry.
- **WARMUP**
  - `cnt` increments each cycle that `stall_req`=0.
  - When `cnt` equals `WARMUP_CYCLES`, the state goes to RUN.
  - With `WARMUP_CYCLES`=0, the state goes to RUN on the first edge.
- **RUN**
  - Stays in RUN until `flush_req` is seen.
- **WARMUP/RUN with `flush_req`=1**
  - The state goes to DRAIN. `flush_req` takes priority over the warm-up transition.
- **DRAIN**
  - `if_stall` is forced to 1; the downstream stages keep running under normal backpressure.
  - When all three FIFO empty flags are 1, the state goes to FLUSH.
  - When `cnt` reaches `DRAIN_TIMEOUT`-1 before that, the state goes to FLUSH and `drain_timeout` is set.
  - `stall_req` does not pause the timeout count.
- **FLUSH**
  - Lasts exactly one cycle.
  - `fifo_flush`=1 and all four stalls are 1.
  - The next state is WARMUP.
- `flush_req` is ignored while in DRAIN or FLUSH.
- Stall equations in WARMUP/RUN/DRAIN (registered):
  - `rn_stall` = `stall_req` | ~`rn_ready`
  - `mp_stall` = `stall_req` | `fifo_mp_rn_full`
  - `id_stall` = `stall_req` | `fifo_id_mp_full`
  - `if_stall` = `stall_req` | `fifo_if_id_full` | (next state == DRAIN)
- `schedule_en` = (next state == RUN) & ~`stall_req`.
- `drain_timeout` clears only on reset.

## Timing
- All outputs are registered. An input sampled at edge t is visible after edge t.
- Reset values:
  - all four stalls = 1
  - `schedule_en` = 0
  - `fifo_flush` = 0
  - `ctrl_state` = 0
  - `drain_timeout` = 0
  - `cnt` = 0
- Reset assertion forces these values immediately, including mid-DRAIN or mid-FLUSH. No pending flush survives reset.
- After reset deassertion with `stall_req`=0 and no backpressure:
  - stalls drop at edge 1.
  - `schedule_en` first reads 1 after edge `WARMUP_CYCLES`+1.
- Each cycle of `stall_req`=1 during WARMUP delays that edge by one.
- Flush sequence:
  - `flush_req` at edge t → DRAIN and `if_stall`=1 after edge t.
  - `schedule_en`=0 after edge t.
  - `fifo_flush` pulses for exactly one cycle after the edge on which all FIFOs are seen empty (or the timeout fires).
  - WARMUP begins on the following cycle.
- FIFO-full and `rn_ready` changes reach the stall outputs with 1-cycle latency. The FIFOs must therefore provide at least one entry of slack.

## Configuration
- Macro: `QU_PIPE_CTRL_STALL_CHAIN_EN`.
- **Defined:** stalls propagate upstream.
  - `mp_stall` |= `rn_stall` term.
  - `id_stall` |= `mp_stall` term.
  - `if_stall` |= `id_stall` term.
  - All terms are computed combinationally from the next-state terms and registered together, so latency is unchanged.
- **Undefined:** each stall depends only on its own equation above.

## Test plan
- **Reset/warm-up:** hold `rst`=0 for 5 cycles, then release with `WARMUP_CYCLES`=20 and all inputs idle → stalls 0 after edge 1, `schedule_en`=0 through edge 20, `schedule_en`=1 after edge 21, `ctrl_state`=1.
- **Backpressure:** in RUN, pulse `fifo_id_mp_full`=1 for 3 cycles → `id_stall`=1 for exactly those 3 cycles delayed by one, other stalls 0. With `QU_PIPE_CTRL_STALL_CHAIN_EN`, `rn_ready`=0 → all four stalls 1 one cycle later.
- **Clean flush:** in RUN, pulse `flush_req`; set the three empty flags to 1 four cycles later → `if_stall`=1 and `schedule_en`=0 during DRAIN, one `fifo_flush` pulse, then WARMUP repeats its 20-cycle count and `drain_timeout`=0.
- **Drain timeout:** `DRAIN_TIMEOUT`=8 with FIFOs never empty → FLUSH entered after 8 DRAIN cycles and `drain_timeout`=1 persists through later RUN.
- **Simultaneous events:** `flush_req`=1 on the same edge WARMUP would finish → DRAIN, not RUN. `flush_req` during DRAIN → no effect. `stall_req`=1 for 5 cycles in WARMUP → `schedule_en` delayed by 5 cycles.
- **Reset mid-operation:** assert `rst`=0 asynchronously during DRAIN → all outputs take their reset values before the next edge.
